// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write-port owner: ALU/load merge, skid buffer, pending-load scoreboard
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   single-cycle ALU result, always accepted
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   load response handshake
//   issue_valid/issue_rd     load issue, marks rd pending
//   dec_valid/dec_rs1/dec_rs2/dec_rd   decode hazard query
//   stall                    combinational hazard flag to decode
//   rf_we/rf_waddr/rf_wdata  registered write port to the register file
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  dec_valid,
  input  logic [ADDR_WIDTH-1:0] dec_rs1,
  input  logic [ADDR_WIDTH-1:0] dec_rs2,
  input  logic [ADDR_WIDTH-1:0] dec_rd,
  output logic                  stall,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_rd;
  logic [XLEN-1:0]       buf_data;
  logic                  rf_is_load;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;

  logic                  alu_req;
  logic                  load_req;
  logic                  sel_valid;
  logic                  sel_load;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  buf_load;
  logic                  buf_drain;

  // The buffer only fills when empty, so a full buffer is the only reason
  // to refuse a load response.
  assign lsu_ready = ~buf_valid;

  // rd=0 handshakes are accepted but turned into no-ops here.
  assign alu_req  = alu_valid & (alu_rd != '0);
  assign load_req = lsu_valid & lsu_ready & (lsu_rd != '0);

  // Fixed priority: ALU, then the older buffered load, then a fresh load.
  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    if (alu_req) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      buf_load  = load_req;
    end else if (buf_valid) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = buf_rd;
      sel_data  = buf_data;
      buf_drain = 1'b1;
    end else if (load_req) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_rd    <= lsu_rd;
      buf_data  <= lsu_data;
    end else if (buf_drain) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_is_load <= 1'b0;
    end else begin
      rf_we      <= sel_valid;
      rf_is_load <= sel_load;
      if (sel_valid) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Clearing on the commit edge means the register file already holds the
  // load data when the stall drops. Set is applied last so it wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we && rf_is_load) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // pending[0] is held at 0, so x0 operands never stall.
  assign stall = dec_valid & (pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]);

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, lsu_valid, issue_valid, dec_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // Reference model: accepted loads wait in a queue and are written whenever
  // no ALU write wants the port; registers stay pending until their load is
  // written back.
  logic [36:0] load_q[$];
  bit          mpend[32];
  logic        exp_we, exp_isload;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic model_reset();
    load_q.delete();
    foreach (mpend[i]) mpend[i] = 0;
    exp_we = 0; exp_isload = 0; exp_addr = 0; exp_data = 0;
  endtask

  // One clock cycle with the currently driven inputs; checks combinational
  // outputs before the edge and registered outputs after it.
  task automatic step();
    logic       nwe, nis;
    logic [4:0] rd;
    logic [31:0] d;
    bit         es;
    #1;
    es = dec_valid && ((dec_rs1 != 0 && mpend[dec_rs1]) ||
                       (dec_rs2 != 0 && mpend[dec_rs2]) ||
                       (dec_rd  != 0 && mpend[dec_rd]));
    chk("lsu_ready", lsu_ready, load_q.size() == 0);
    chk("stall", stall, es);
    if (lsu_valid && load_q.size() == 0 && lsu_rd != 0)
      load_q.push_back({lsu_rd, lsu_data});
    nwe = 0; nis = 0; rd = 0; d = 0;
    if (alu_valid && alu_rd != 0) begin
      nwe = 1; rd = alu_rd; d = alu_data;
    end else if (load_q.size() > 0) begin
      {rd, d} = load_q.pop_front();
      nwe = 1; nis = 1;
    end
    if (exp_we && exp_isload) mpend[exp_addr] = 0;
    if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1;
    exp_we = nwe;
    exp_isload = nis;
    if (nwe) begin exp_addr = rd; exp_data = d; end
    @(posedge clk); #1;
    chk("rf_we", rf_we, exp_we);
    chk("rf_waddr", rf_waddr, exp_addr);
    chk("rf_wdata", rf_wdata, exp_data);
    if (rf_we === 1'b1) chk("no_x0_write", rf_waddr != 0, 1);
  endtask

  initial begin
    idle();
    model_reset();
    dec_valid = 1; dec_rs1 = 9;
    #3;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_stall", stall, 0);
    #9 rst = 1;
    @(posedge clk); #1;
    idle();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", rf_we, 1); chk("alu_addr", rf_waddr, 5); chk("alu_data", rf_wdata, 32'hDEADBEEF);
    idle(); step();
    chk("alu_we_off", rf_we, 0);

    // Collision: ALU first, load next cycle
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h22;
    step();
    chk("col1_addr", rf_waddr, 3); chk("col1_data", rf_wdata, 32'h11); chk("col1_ready", lsu_ready, 0);
    idle(); step();
    chk("col2_addr", rf_waddr, 7); chk("col2_data", rf_wdata, 32'h22); chk("col2_ready", lsu_ready, 1);

    // Starvation: four ALU cycles, load accepted in the first, a second load
    // offered while the buffer is full
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
      lsu_valid = 1;
      if (i == 0) begin lsu_rd = 12; lsu_data = 32'hAAAA; end
      else begin lsu_rd = 13; lsu_data = 32'hBBBB; end
      step();
      if (i > 0) chk("starve_ready", lsu_ready, 0);
    end
    idle(); step();
    chk("starve_addr", rf_waddr, 12); chk("starve_data", rf_wdata, 32'hAAAA);
    step();
    chk("starve_2nd_dropped", rf_we, 0);

    // Scoreboard set / clear
    issue_valid = 1; issue_rd = 9;
    step();
    idle(); dec_valid = 1; dec_rs1 = 9; #1;
    chk("sb_stall_set", stall, 1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    step();
    lsu_valid = 0; step();
    chk("sb_wb", rf_waddr, 9);
    step();
    chk("sb_stall_clr", stall, 0);

    // Same-edge set and clear keeps the bit
    issue_valid = 1; issue_rd = 9; step();
    issue_valid = 0; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h55; step();
    lsu_valid = 0; issue_valid = 1; issue_rd = 9; step();
    issue_valid = 0; step();
    chk("sb_set_wins", stall, 1);
    lsu_valid = 1; lsu_rd = 9; step();
    lsu_valid = 0; step(); step();

    // x0 handling
    idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; step();
    chk("x0_alu", rf_we, 0);
    alu_valid = 0; lsu_valid = 1; lsu_rd = 0; step();
    chk("x0_lsu", rf_we, 0);
    lsu_valid = 0; issue_valid = 1; issue_rd = 0; step();
    issue_valid = 0; dec_valid = 1; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; step();
    chk("x0_nostall", stall, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom); lsu_data = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0); issue_rd = 5'($urandom);
      dec_valid = 1'($urandom_range(0, 1));
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
      step();
    end

    // Async reset with a load buffered and x4 pending
    idle(); step(); step(); step();
    issue_valid = 1; issue_rd = 4; step();
    idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
    dec_valid = 1; dec_rs1 = 4;
    step();
    chk("pre_rst_ready", lsu_ready, 0);
    chk("pre_rst_stall", stall, 1);
    idle(); dec_valid = 1; dec_rs1 = 4;
    #3 rst = 0;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_ready", lsu_ready, 1);
    chk("arst_stall", stall, 0);
    model_reset();
    #2 rst = 1;
    @(posedge clk); #1;
    chk("post_rst_we", rf_we, 0);
    step(); step();
    chk("post_rst_nostale", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side companion of the CPU register file: the single owner of its write port (we/waddr/wdata).
- Merges two result sources: single-cycle ALU results and variable-latency load responses from the load/store unit.
- Registers the selected write and drives it to the register file.
- Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards against outstanding loads.

Parameters:
- XLEN, 32, data width of results and register file words.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of architectural registers; scoreboard depth.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure, always accepted.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load response valid.
- lsu_ready  out  1  load response accepted when lsu_valid & lsu_ready.
- lsu_rd  in  ADDR_WIDTH  load destination register.
- lsu_data  in  XLEN  load data.
- issue_valid  in  1  a load is issued this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issued load.
- dec_valid  in  1  decode presents an instruction for hazard check.
- dec_rs1, dec_rs2, dec_rd  in  ADDR_WIDTH each  decode source and destination indices.
- stall  out  1  combinational hazard flag to decode.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  XLEN  register file write data.

Behaviour:
- Reset (rst=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, skid buffer empty, all pending bits 0, rf_is_load=0. A reset mid-operation drops any buffered load. lsu_ready=1 and stall=0 while reset is held.
- Effective requests:
  - ALU request: alu_valid & (alu_rd != 0).
  - Load request: lsu_valid & (lsu_rd != 0).
  - A handshake with rd=0 is accepted and discarded; it causes no write and no scoreboard change.
- Skid buffer: one entry {rd, data}, buf_valid.
  - lsu_ready = ~buf_valid.
- Selection each cycle, fixed priority:
  - ALU first.
  - Then the buffered load.
  - Then a load accepted this cycle.
- Buffering: a load accepted in a cycle where it is not selected (ALU request present) goes into the buffer.
  - A buffered load not selected stays buffered.
  - The buffer never overflows, because lsu_ready is low while it is full.
- Output stage, 1-cycle latency:
  - At the edge, rf_we/rf_waddr/rf_wdata take the selected write.
  - rf_is_load is set if the selected write came from a load.
  - If nothing is selected, rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Scoreboard, pending[NUM_REGS]:
  - Set at the edge when issue_valid & issue_rd != 0.
  - Cleared at the edge ending a cycle where rf_we & rf_is_load, for index rf_waddr.
  - This is the same edge the register file commits the data, so the read in the next cycle sees the new value.
  - Same-index set and clear on the same edge: set wins.
  - pending[0] is constant 0.
- stall = dec_valid & (pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]).
  - Any index of 0 contributes 0.
  - Purely combinational from the current pending bits.
- Decode guarantees it issues no load to an rd that is already pending (WAW is covered by stall). If that happens anyway, the bit stays set.
- Writes to rf_waddr=0 never occur: rf_we is never asserted with address 0.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1, rf_we=0 in N+2.
- Collision: ALU (rd=3, 0x11) and load (rd=7, 0x22) in the same cycle N:
  - cycle N+1: write x3=0x11 and lsu_ready=0.
  - cycle N+2: write x7=0x22 and lsu_ready=1.
- Back-to-back ALU starvation:
  - ALU valid cycles N..N+3, load accepted in N -> load written in N+5.
  - lsu_ready=0 during N+1..N+4.
  - A second lsu_valid during that window is not accepted.
- Scoreboard:
  - issue_valid, issue_rd=9 at cycle N -> stall=1 for dec_rs1=9 from N+1.
  - Load response rd=9 in cycle M -> rf_we in M+1; stall=0 from M+2.
  - Same-edge set/clear for rd=9 -> stall stays 1.
- x0 handling:
  - alu_rd=0 or lsu_rd=0 -> rf_we stays 0.
  - issue_rd=0 -> no pending bit.
  - dec_rs1=0 -> never stalls.
- Async reset: with a load buffered and pending[4]=1, drive rst=0 mid-cycle -> rf_we=0, lsu_ready=1 and stall=0 immediately. After release, no stale write appears.
